// File: rtl/regbank85.sv
// regbank85: 8085 register file (A, B, C, D, E, H, L, SP) with a byte write
// port, a registered byte read port and a pair port for BC/DE/HL/SP
// increment, decrement and load. DATASIZE is expected to be a multiple of 4.
module regbank85 #(
    parameter int DATASIZE = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_enb_i,
    input  logic [2:0]            wr_sel_i,
    input  logic [DATASIZE-1:0]   wr_data_i,
    input  logic                  rd_enb_i,
    input  logic [2:0]            rd_sel_i,
    output logic [DATASIZE-1:0]   rd_data_o,
    output logic                  rd_valid_o,
    input  logic [1:0]            pair_sel_i,
    input  logic [1:0]            pair_op_i,
    input  logic [2*DATASIZE-1:0] pair_data_i,
    output logic [2*DATASIZE-1:0] pair_out_o,
    output logic                  pair_zero_o
);

    localparam int PW = 2 * DATASIZE;

    logic [DATASIZE-1:0] a_q, b_q, c_q, d_q, e_q, h_q, l_q;
    logic [DATASIZE-1:0] a_d, b_d, c_d, d_d, e_d, h_d, l_d;
    logic [PW-1:0]       sp_q, sp_d;
    logic [DATASIZE-1:0] rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [PW-1:0]       pair_out_q, pair_out_d;
    logic                pair_zero_q, pair_zero_d;

    logic [PW-1:0]       pair_cur;
    logic [PW-1:0]       pair_res;
    logic                pair_busy;
    logic                wr_hit;

    // Next-state for storage, read port and pair port; a pair op on the
    // pair that owns the written byte suppresses that byte write.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        e_d = e_q;
        h_d = h_q;
        l_d = l_q;
        sp_d = sp_q;

        case (pair_sel_i)
            2'b00:   pair_cur = {b_q, c_q};
            2'b01:   pair_cur = {d_q, e_q};
            2'b10:   pair_cur = {h_q, l_q};
            default: pair_cur = sp_q;
        endcase

        case (pair_op_i)
            2'b01:   pair_res = pair_cur + PW'(1);
            2'b10:   pair_res = pair_cur - PW'(1);
            2'b11:   pair_res = pair_data_i;
            default: pair_res = pair_cur;
        endcase

        pair_busy = (pair_op_i != 2'b00);
        // Byte selects 00x/01x/10x map onto pairs BC/DE/HL; SP has no bytes.
        wr_hit = pair_busy && (pair_sel_i != 2'b11) && (wr_sel_i[2:1] == pair_sel_i);

        if (wr_enb_i && !wr_hit) begin
            case (wr_sel_i)
                3'b000:  b_d = wr_data_i;
                3'b001:  c_d = wr_data_i;
                3'b010:  d_d = wr_data_i;
                3'b011:  e_d = wr_data_i;
                3'b100:  h_d = wr_data_i;
                3'b101:  l_d = wr_data_i;
                3'b111:  a_d = wr_data_i;
                default: ;
            endcase
        end

        if (pair_busy) begin
            case (pair_sel_i)
                2'b00:   {b_d, c_d} = pair_res;
                2'b01:   {d_d, e_d} = pair_res;
                2'b10:   {h_d, l_d} = pair_res;
                default: sp_d = pair_res;
            endcase
        end

        case (pair_sel_i)
            2'b00:   pair_out_d = {b_d, c_d};
            2'b01:   pair_out_d = {d_d, e_d};
            2'b10:   pair_out_d = {h_d, l_d};
            default: pair_out_d = sp_d;
        endcase

        if ((pair_op_i == 2'b01) || (pair_op_i == 2'b10)) begin
            pair_zero_d = (pair_res == '0);
        end else begin
            pair_zero_d = pair_zero_q;
        end

        rd_valid_d = rd_enb_i;
        rd_data_d  = rd_data_q;
        if (rd_enb_i) begin
            case (rd_sel_i)
                3'b000:  rd_data_d = b_q;
                3'b001:  rd_data_d = c_q;
                3'b010:  rd_data_d = d_q;
                3'b011:  rd_data_d = e_q;
                3'b100:  rd_data_d = h_q;
                3'b101:  rd_data_d = l_q;
                3'b111:  rd_data_d = a_q;
                default: rd_data_d = '0;
            endcase
        end
    end

    // State and registered outputs; everything clears on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            e_q         <= '0;
            h_q         <= '0;
            l_q         <= '0;
            sp_q        <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            pair_out_q  <= '0;
            pair_zero_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            e_q         <= e_d;
            h_q         <= h_d;
            l_q         <= l_d;
            sp_q        <= sp_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            pair_out_q  <= pair_out_d;
            pair_zero_q <= pair_zero_d;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign pair_out_o  = pair_out_q;
    assign pair_zero_o = pair_zero_q;

endmodule

// File: tb/tb_regbank85.sv
// Bench for regbank85: directed steps from the feature list followed by a
// randomized run, all checked against a byte-array model of the register file.
module tb_regbank85;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wr_enb_i;
    logic [2:0]  wr_sel_i;
    logic [7:0]  wr_data_i;
    logic        rd_enb_i;
    logic [2:0]  rd_sel_i;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o;
    logic [1:0]  pair_sel_i;
    logic [1:0]  pair_op_i;
    logic [15:0] pair_data_i;
    logic [15:0] pair_out_o;
    logic        pair_zero_o;

    int tests = 0;
    int fails = 0;

    // Model: m[sel] holds the byte addressed by 8085 select code sel
    // (index 6 is unused and stays zero); pair p is {m[2p], m[2p+1]}.
    logic [7:0]  m [0:7];
    logic [15:0] sp;
    logic [7:0]  e_rd_data;
    logic        e_rd_valid;
    logic [15:0] e_pair_out;
    logic        e_pair_zero;

    regbank85 #(.DATASIZE(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_enb_i    (wr_enb_i),
        .wr_sel_i    (wr_sel_i),
        .wr_data_i   (wr_data_i),
        .rd_enb_i    (rd_enb_i),
        .rd_sel_i    (rd_sel_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .pair_sel_i  (pair_sel_i),
        .pair_op_i   (pair_op_i),
        .pair_data_i (pair_data_i),
        .pair_out_o  (pair_out_o),
        .pair_zero_o (pair_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pair_get(input int p);
        if (p == 3) return sp;
        return {m[2*p], m[2*p+1]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
        sp          = 16'h0000;
        e_rd_data   = 8'h00;
        e_rd_valid  = 1'b0;
        e_pair_out  = 16'h0000;
        e_pair_zero = 1'b0;
    endtask

    // Apply one clock edge worth of behaviour to the model.
    task automatic model_edge();
        int          p;
        logic [15:0] v;
        bit          conflict;
        p = int'(pair_sel_i);
        e_rd_valid = rd_enb_i;
        if (rd_enb_i) e_rd_data = (rd_sel_i == 3'd6) ? 8'h00 : m[rd_sel_i];
        v = pair_get(p);
        case (pair_op_i)
            2'd1: v = 16'((int'(v) + 1) % 65536);
            2'd2: v = 16'((int'(v) + 65535) % 65536);
            2'd3: v = pair_data_i;
            default: ;
        endcase
        conflict = (pair_op_i != 2'd0) && (p != 3) && (int'(wr_sel_i) / 2 == p);
        if (wr_enb_i && wr_sel_i != 3'd6 && !conflict) m[wr_sel_i] = wr_data_i;
        if (pair_op_i != 2'd0) begin
            if (p == 3) sp = v;
            else begin
                m[2*p]   = v[15:8];
                m[2*p+1] = v[7:0];
            end
        end
        if (pair_op_i == 2'd1 || pair_op_i == 2'd2) e_pair_zero = (v == 16'h0000);
        e_pair_out = pair_get(p);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd_valid"}, 32'(rd_valid_o), 32'(e_rd_valid));
        check({tag, ".rd_data"}, 32'(rd_data_o), 32'(e_rd_data));
        check({tag, ".pair_out"}, 32'(pair_out_o), 32'(e_pair_out));
        check({tag, ".pair_zero"}, 32'(pair_zero_o), 32'(e_pair_zero));
    endtask

    task automatic idle();
        wr_enb_i = 0; wr_sel_i = 3'd6; wr_data_i = 8'h00;
        rd_enb_i = 0; rd_sel_i = 3'd0;
        pair_op_i = 2'd0; pair_data_i = 16'h0000;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    task automatic wr(input logic [2:0] s, input logic [7:0] d);
        idle(); wr_enb_i = 1; wr_sel_i = s; wr_data_i = d;
        step("wr");
    endtask

    task automatic rd(input logic [2:0] s);
        idle(); rd_enb_i = 1; rd_sel_i = s;
        step("rd");
    endtask

    task automatic pop(input logic [1:0] p, input logic [1:0] op, input logic [15:0] d);
        idle(); pair_sel_i = p; pair_op_i = op; pair_data_i = d;
        step("pair");
    endtask

    initial begin
        rst_ni = 1'b0;
        pair_sel_i = 2'd0;
        idle();
        model_reset();
        #12;
        check_all("reset");
        #4 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Reset state read-back of every select code.
        for (int s = 0; s < 8; s++) begin
            rd(3'(s));
            check("rst_read", 32'(rd_data_o), 32'h00);
        end
        check("rst_pair", 32'(pair_out_o), 32'h0000);

        // Byte write and read-back.
        wr(3'd0, 8'hA5);
        wr(3'd1, 8'h5A);
        wr(3'd7, 8'h3C);
        rd(3'd0); check("rd_B", 32'(rd_data_o), 32'hA5);
        rd(3'd1); check("rd_C", 32'(rd_data_o), 32'h5A);
        rd(3'd7); check("rd_A", 32'(rd_data_o), 32'h3C);
        pop(2'd0, 2'd0, 16'h0000);
        check("BC_out", 32'(pair_out_o), 32'hA55A);

        // HL wrap in both directions.
        pop(2'd2, 2'd3, 16'hFFFF);
        check("HL_load", 32'(pair_out_o), 32'hFFFF);
        pop(2'd2, 2'd1, 16'h0000);
        check("HL_inc", 32'(pair_out_o), 32'h0000);
        check("HL_inc_z", 32'(pair_zero_o), 32'h1);
        pop(2'd2, 2'd2, 16'h0000);
        check("HL_dec", 32'(pair_out_o), 32'hFFFF);
        check("HL_dec_z", 32'(pair_zero_o), 32'h0);

        // SP decrement to zero; select 110 always reads zero.
        pop(2'd3, 2'd3, 16'h0001);
        pop(2'd3, 2'd2, 16'h0000);
        check("SP_dec", 32'(pair_out_o), 32'h0000);
        check("SP_dec_z", 32'(pair_zero_o), 32'h1);
        pop(2'd3, 2'd3, 16'hBEEF);
        rd(3'd6); check("rd_M", 32'(rd_data_o), 32'h00);

        // Byte write against a pair load on the same pair, then another pair.
        idle(); wr_enb_i = 1; wr_sel_i = 3'd2; wr_data_i = 8'h77;
        pair_sel_i = 2'd1; pair_op_i = 2'd3; pair_data_i = 16'h1234;
        step("conflict_D");
        check("DE_win", 32'(pair_out_o), 32'h1234);
        rd(3'd2); check("D_not77", 32'(rd_data_o), 32'h12);
        idle(); wr_enb_i = 1; wr_sel_i = 3'd0; wr_data_i = 8'h77;
        pair_sel_i = 2'd1; pair_op_i = 2'd3; pair_data_i = 16'h1234;
        step("conflict_B");
        rd(3'd0); check("B_77", 32'(rd_data_o), 32'h77);
        check("DE_1234", 32'(pair_out_o), 32'h1234);

        // Same-cycle read and write of one register.
        idle(); wr_enb_i = 1; wr_sel_i = 3'd3; wr_data_i = 8'h99;
        rd_enb_i = 1; rd_sel_i = 3'd3;
        step("rw_same");
        check("rw_old", 32'(rd_data_o), 32'h34);
        rd(3'd3); check("rw_new", 32'(rd_data_o), 32'h99);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            wr_enb_i    = 1'($urandom_range(0, 1));
            wr_sel_i    = 3'($urandom_range(0, 7));
            wr_data_i   = 8'($urandom);
            rd_enb_i    = 1'($urandom_range(0, 1));
            rd_sel_i    = 3'($urandom_range(0, 7));
            pair_sel_i  = 2'($urandom_range(0, 3));
            pair_op_i   = 2'($urandom_range(0, 3));
            pair_data_i = ($urandom_range(0, 7) == 0) ? 16'(($urandom_range(0, 1) == 0) ? 16'h0001 : 16'hFFFF)
                                                      : 16'($urandom);
            step("rand");
        end

        // Asynchronous reset in the middle of a read burst.
        rd(3'd7);
        idle(); rd_enb_i = 1; rd_sel_i = 3'd0; pair_sel_i = 2'd1;
        step("burst");
        #3 rst_ni = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        #2 rst_ni = 1'b1;
        #1;
        check("rel_valid", 32'(rd_valid_o), 32'h0);
        idle();
        step("post_reset");
        rd(3'd0); check("post_B", 32'(rd_data_o), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regbank85.md
# regbank85

Register bank for the 8085 core datapath. It holds A, B, C, D, E, H, L and the 16-bit stack pointer SP. A byte-wide write port loads registers. A registered read port returns data one cycle after a request. A pair port reads, loads, increments or decrements BC/DE/HL/SP.

## Interface
- DATASIZE, 8, byte width in bits; must be a multiple of 4; pairs are 2*DATASIZE wide
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-low reset
- wr_enb  in  1  byte write strobe
- wr_sel  in  3  write target, 8085 encoding: 000 B, 001 C, 010 D, 011 E, 100 H, 101 L, 110 none (M), 111 A
- wr_data  in  DATASIZE  byte write data
- rd_enb  in  1  byte read request
- rd_sel  in  3  read source, same encoding as wr_sel; 110 reads zero
- rd_data  out  DATASIZE  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data is valid while it is high
- pair_sel  in  2  pair select: 00 BC, 01 DE, 10 HL, 11 SP
- pair_op  in  2  pair operation: 00 hold, 01 increment, 10 decrement, 11 load pair_data
- pair_data  in  2*DATASIZE  pair load value; high byte is B/D/H/SP[hi]
- pair_out  out  2*DATASIZE  registered value of the selected pair after the edge
- pair_zero  out  1  registered flag; 1 when the pair result of the last inc/dec is zero

## Operation
- Storage: A, B, C, D, E, H, L (DATASIZE each) and SP (2*DATASIZE).
  - BC = {B,C}, DE = {D,E}, HL = {H,L}.
  - SP is reachable only through the pair port.
- Byte write: when wr_enb=1, the register at wr_sel takes wr_data on the edge.
  - wr_sel=110 discards the write and changes no state.
- Byte read: when rd_enb=1, rd_data captures the value the register at rd_sel holds before the edge, and rd_valid=1 for that one cycle.
  - When rd_enb=0, rd_valid=0 and rd_data holds its last value.
- Pair op on the edge:
  - 01: pair <= pair+1, modulo 2^(2*DATASIZE); FFFF wraps to 0000 for DATASIZE=8.
  - 10: pair <= pair-1, modulo; 0000 wraps to FFFF.
  - 11: pair <= pair_data.
  - 00: the pair is unchanged.
- pair_out is the post-edge value of the pair selected by pair_sel. It updates every cycle, whatever the op.
- pair_zero:
  - Updated only on 01/10, set to (result == 0).
  - Holds its value on 00 and 11.
- Simultaneous byte write and pair op:
  - If wr_sel targets a byte of the pair being operated on, the pair op wins and the byte write is dropped entirely.
  - Writes to any other register proceed in the same cycle.
- Same-cycle read and write of one register: rd_data returns the old value; the new value is visible to a read one cycle later.
- The design has no other internal state and no multi-cycle operations.

## Timing
- Reset (rst=0, asynchronous): all registers and SP clear to 0; rd_data=0, rd_valid=0, pair_out=0, pair_zero=0.
- Reset mid-operation: any in-flight read is abandoned; rd_valid is 0 in the first cycle after rst returns to 1.
- Read latency: 1 cycle, rd_enb at edge N -> rd_valid/rd_data after edge N.
  - Back-to-back reads are allowed every cycle.
- Pair latency: 1 cycle; op at edge N -> pair_out/pair_zero reflect the result after edge N.
- Write-to-pair visibility: a byte write at edge N shows in pair_out after edge N when that pair is selected.
- All outputs change only on the rising edge of clk or on assertion of rst.

## Test plan
- Reset then read all registers: pulse rst low, issue rd_enb for sel 000..111 -> every rd_data=00 with rd_valid=1, pair_out=0000.
- Write/read: write B=A5, C=5A, A=3C, then read each -> rd_data A5, 5A, 3C one cycle after each request; pair_sel=00 -> pair_out=A55A.
- Pair wrap: load HL=FFFF (op 11), then increment -> pair_out=0000, pair_zero=1; decrement -> FFFF, pair_zero=0.
- SP: load SP=0001, decrement -> 0000 with pair_zero=1; byte reads never return SP.
- Conflict: in one cycle, wr_sel=010 (D) wr_data=77 with pair_sel=01 op 11 pair_data=1234 -> DE=1234 and D≠77; repeat with wr_sel=000 -> B=77 and DE=1234.
- Async reset mid-stream: assert rst between clock edges during a read burst -> outputs zero immediately, rd_valid=0 after release.
